mips_mem_responder: RTL and testbench
=====================================

Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core's unified memory bus (adr, writedata, memwrite, readdata).
- Provides word-addressed program/data RAM, a small memory-mapped I/O window (cycle counter, output FIFO, status, error address), and a testbench/boot preload port.
- The output FIFO drains to an external consumer over a valid/ready handshake.
- Sits at top level beside the mips core; one instance serves both instruction fetch and data access.

Parameters:
- RAM_WORDS, 256: RAM depth in 32-bit words (power of 2); RAM spans byte addresses 0 .. RAM_WORDS*4-4.
- FIFO_DEPTH, 8: output FIFO entries (power of 2, 2..128).
- IO_BASE, 32'hFFFF_FF00: byte base of the I/O window.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- adr, in, 32: byte address from the core.
- writedata, in, 32: store data from the core.
- memwrite, in, 1: store strobe; one write per rising edge while high.
- readdata, out, 32: combinational read data for the current adr.
- ld_we, in, 1: preload write enable.
- ld_addr, in, log2(RAM_WORDS): preload word address.
- ld_data, in, 32: preload data.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: consumer accepts the head.
- out_data, out, 32: FIFO head word; 0 when empty.
- err_o, out, 1: sticky bus-error flag (mirror of STATUS[0]).

Behaviour:
- Reset (async) clears: cycle counter=0, FIFO read/write pointers and count=0, err=0, ovf=0, ERRADDR=0.
  - Resulting outputs: out_valid=0, out_data=0, err_o=0.
  - RAM contents are not cleared; reset mid-operation preserves RAM and discards FIFO contents.
- Address decode (byte addresses):
  - RAM: adr < RAM_WORDS*4. Word index is adr[log2(RAM_WORDS)+1:2].
  - CYCLE: IO_BASE+0x0, read-only.
  - OUT: IO_BASE+0x4, write-only push; reads return 0.
  - STATUS: IO_BASE+0x8, read/write-1-to-clear.
  - ERRADDR: IO_BASE+0xC, read-only.
  - Any other address, or adr[1:0]!=0, is unmapped.
- Reads:
  - Purely combinational, zero latency, no side effects (the core drives adr in every state).
  - Unmapped or unaligned reads return 32'hDEADBEEF and set no flags.
- Writes occur on the rising clk edge when memwrite=1.
  - RAM: word updated; readdata shows the old word during the write cycle and the new word after the edge.
  - OUT: push writedata if FIFO not full. If full, drop the data and set ovf. Fullness is sampled from the pre-edge state, so a push while full with a simultaneous pop is still dropped.
  - STATUS: writedata[0]=1 clears err; writedata[1]=1 clears ovf. If a new error occurs in the same cycle, the set wins.
  - CYCLE and ERRADDR: write ignored, no error.
  - Unmapped or unaligned write: ignored; err=1; ERRADDR=adr (overwritten by each subsequent faulting write).
- STATUS read layout:
  - bit0 err; bit1 ovf; bit2 fifo_empty; bit3 fifo_full.
  - bits[15:8] fifo count.
  - All other bits 0.
- Cycle counter: increments every clk edge after reset; wraps 32'hFFFF_FFFF -> 0.
- Output FIFO:
  - out_valid = (count != 0).
  - Pop on an edge where out_valid & out_ready.
  - Push and pop in the same cycle (non-empty, non-full): count unchanged, order preserved.
  - Push into an empty FIFO: out_valid=1 the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Preload port:
  - ld_we writes ld_data to RAM[ld_addr] on the clk edge and is honoured during reset.
  - If ld_we and a CPU RAM write hit the same word in the same cycle, the preload data wins; different words are both written.

Test Plan:
- Preload RAM[0..2]=32'h20080005, 32'hAC080040, 32'h08000000, then release reset -> readdata at adr 0/4/8 returns those words combinationally; CYCLE read equals edges since reset.
- CPU writes 32'h12345678 to adr 0x40 -> readdata shows the old value in the write cycle and 32'h12345678 after the edge; a simultaneous ld_we to word 0x10 with 32'hAAAA0000 leaves 32'hAAAA0000.
- Push 9 words (1..9) to IO_BASE+4 with out_ready=0, FIFO_DEPTH=8 -> STATUS = 32'h0000_080A (count 8, full, ovf); raise out_ready -> out_data sequence 1..8, then out_valid=0 and STATUS fifo_empty=1.
- Write to adr 0x402 (unaligned/unmapped) -> err_o=1, ERRADDR=32'h0000_0402, RAM unchanged; write 32'h1 to STATUS -> err_o=0; a read of 0x8000_0000 returns 32'hDEADBEEF with err_o still 0.
- Assert reset mid-stream with 3 FIFO entries and err=1 -> out_valid=0, err_o=0 immediately (async), CYCLE reads 0 afterwards, RAM word at 0x40 still 32'h12345678.
- Force the cycle counter to 32'hFFFF_FFFE and run 2 edges -> reads 32'hFFFF_FFFF, then 32'h0.

Source files
------------

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: memory-side responder for the multicycle MIPS core's
// unified bus. Word-addressed RAM plus an I/O window at IO_BASE:
//   +0x0 CYCLE (ro), +0x4 OUT push (wo), +0x8 STATUS (r/w1c), +0xC ERRADDR (ro).
// Ports:
//   clk, reset          clock, async active-high reset
//   adr, writedata      core byte address and store data
//   memwrite            store strobe, one write per rising edge
//   readdata            combinational read data for adr
//   ld_we/ld_addr/ld_data  boot preload into RAM (works during reset)
//   out_valid/out_ready/out_data  output FIFO head handshake
//   err_o               sticky bus-error flag (STATUS[0])
module mips_mem_responder #(
   parameter int unsigned RAM_WORDS  = 256,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [31:0]                  adr,
   input  logic [31:0]                  writedata,
   input  logic                         memwrite,
   output logic [31:0]                  readdata,
   input  logic                         ld_we,
   input  logic [$clog2(RAM_WORDS)-1:0] ld_addr,
   input  logic [31:0]                  ld_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_data,
   output logic                         err_o
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [31:0] A_CYCLE   = IO_BASE;
   localparam logic [31:0] A_OUT     = IO_BASE + 32'h4;
   localparam logic [31:0] A_STATUS  = IO_BASE + 32'h8;
   localparam logic [31:0] A_ERRADDR = IO_BASE + 32'hC;

   logic [31:0]   ram [RAM_WORDS];
   logic [31:0]   fifo_mem [FIFO_DEPTH];

   logic [31:0]   cycle_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          err_q;
   logic          ovf_q;
   logic [31:0]   erraddr_q;

   logic          aligned_c;
   logic          hit_ram_c;
   logic          hit_cyc_c;
   logic          hit_out_c;
   logic          hit_stat_c;
   logic          hit_erra_c;
   logic          unmapped_c;
   logic [AW-1:0] ram_idx_c;
   logic          fifo_empty_c;
   logic          fifo_full_c;
   logic          push_c;
   logic          pop_c;
   logic          fault_c;
   logic          wr_stat_c;
   logic          err_n_c;
   logic          ovf_n_c;
   logic [31:0]   status_c;

   // Address decode; I/O registers match only on exact aligned addresses.
   always_comb begin
      aligned_c  = (adr[1:0] == 2'b00);
      hit_ram_c  = aligned_c && (adr < RAM_BYTES);
      hit_cyc_c  = aligned_c && (adr == A_CYCLE);
      hit_out_c  = aligned_c && (adr == A_OUT);
      hit_stat_c = aligned_c && (adr == A_STATUS);
      hit_erra_c = aligned_c && (adr == A_ERRADDR);
      unmapped_c = !(hit_ram_c || hit_cyc_c || hit_out_c || hit_stat_c || hit_erra_c);
      ram_idx_c  = adr[AW+1:2];
   end

   // FIFO status and write-side strobes; fullness uses pre-edge state.
   always_comb begin
      fifo_empty_c = (count_q == '0);
      fifo_full_c  = (count_q == CW'(FIFO_DEPTH));
      pop_c        = !fifo_empty_c && out_ready;
      push_c       = memwrite && hit_out_c && !fifo_full_c;
      fault_c      = memwrite && unmapped_c;
      wr_stat_c    = memwrite && hit_stat_c;
      // A new event in the same cycle as a clear wins.
      err_n_c      = fault_c || (err_q && !(wr_stat_c && writedata[0]));
      ovf_n_c      = (memwrite && hit_out_c && fifo_full_c) ||
                     (ovf_q && !(wr_stat_c && writedata[1]));
      status_c     = {16'h0000, 8'(count_q), 4'h0,
                      fifo_full_c, fifo_empty_c, ovf_q, err_q};
   end

   // Zero-latency, side-effect-free read mux.
   always_comb begin
      readdata = 32'hDEAD_BEEF;
      if (hit_ram_c)       readdata = ram[ram_idx_c];
      else if (hit_cyc_c)  readdata = cycle_q;
      else if (hit_out_c)  readdata = 32'h0000_0000;
      else if (hit_stat_c) readdata = status_c;
      else if (hit_erra_c) readdata = erraddr_q;
   end

   // RAM has no reset; preload is ordered last so it wins a same-word collision.
   always_ff @(posedge clk) begin
      if (memwrite && hit_ram_c) ram[ram_idx_c] <= writedata;
      if (ld_we)                 ram[ld_addr]   <= ld_data;
   end

   // FIFO storage (contents are meaningless once pointers are reset).
   always_ff @(posedge clk) begin
      if (push_c) fifo_mem[wr_ptr_q] <= writedata;
   end

   // Control state: counter, FIFO pointers, sticky flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         erraddr_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_c) - CW'(pop_c);
         err_q   <= err_n_c;
         ovf_q   <= ovf_n_c;
         if (fault_c) erraddr_q <= adr;
      end
   end

   always_comb begin
      out_valid = !fifo_empty_c;
      out_data  = fifo_empty_c ? 32'h0000_0000 : fifo_mem[rd_ptr_q];
      err_o     = err_q;
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: directed stimulus, a queue/array reference
// model updated on each clock edge, a negedge compare process, and literal
// expectations for the main scenarios.
module tb_mips_mem_responder;

   localparam logic [31:0] IOB = 32'hFFFF_FF00;

   logic        clk;
   logic        reset;
   logic [31:0] adr;
   logic [31:0] writedata;
   logic        memwrite;
   logic [31:0] readdata;
   logic        ld_we;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        err_o;

   int checks = 0;
   int errors = 0;
   int poke_seq = 0;

   mips_mem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(8), .IO_BASE(IOB)) dut (
      .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
      .memwrite(memwrite), .readdata(readdata), .ld_we(ld_we),
      .ld_addr(ld_addr), .ld_data(ld_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_mem [256];
   bit          m_valid [256];
   logic [31:0] m_q [$];
   logic [31:0] m_cyc = 0;
   bit          m_err = 0;
   bit          m_ovf = 0;
   logic [31:0] m_erra = 0;
   int          poke_seen = 0;

   function automatic bit m_mapped(input logic [31:0] a);
      if (a[1:0] != 2'b00) return 1'b0;
      return (a < 32'd1024) || (a == IOB) || (a == IOB + 32'd4) ||
             (a == IOB + 32'd8) || (a == IOB + 32'd12);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
      logic [31:0] st;
      known = 1'b1;
      st = {16'h0, 8'(m_q.size()), 4'h0, m_q.size() == 8, m_q.size() == 0, m_ovf, m_err};
      if (!m_mapped(a)) return 32'hDEAD_BEEF;
      if (a < 32'd1024) begin
         known = m_valid[a[9:2]];
         return m_mem[a[9:2]];
      end
      if (a == IOB) return m_cyc;
      if (a == IOB + 32'd8) return st;
      if (a == IOB + 32'd12) return m_erra;
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (memwrite && m_mapped(adr) && adr < 32'd1024) begin
         m_mem[adr[9:2]] = writedata;
         m_valid[adr[9:2]] = 1'b1;
      end
      if (ld_we) begin
         m_mem[ld_addr] = ld_data;
         m_valid[ld_addr] = 1'b1;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cyc = 0; m_q.delete(); m_err = 0; m_ovf = 0; m_erra = 0;
      end else begin
         int pre;
         bit fault, wstat, wout;
         pre   = m_q.size();
         fault = memwrite && !m_mapped(adr);
         wstat = memwrite && adr == IOB + 32'd8;
         wout  = memwrite && adr == IOB + 32'd4;
         if (poke_seq != poke_seen) begin
            poke_seen = poke_seq;
            m_cyc = 32'hFFFF_FFFE;
         end
         m_cyc = m_cyc + 32'd1;
         if (pre != 0 && out_ready) void'(m_q.pop_front());
         if (wout && pre < 8) m_q.push_back(writedata);
         m_ovf = (wout && pre == 8) ? 1'b1 : ((wstat && writedata[1]) ? 1'b0 : m_ovf);
         m_err = fault ? 1'b1 : ((wstat && writedata[0]) ? 1'b0 : m_err);
         if (fault) m_erra = adr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic [31:0] e;
      bit known;
      e = m_read(adr, known);
      if (known) chk("readdata", readdata, e);
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("out_data", out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
      chk("err_o", 32'(err_o), 32'(m_err));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
      adr = a;
      #1;
      chk(name, readdata, exp);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      adr = a; writedata = d; memwrite = 1'b1;
      step();
      memwrite = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      adr = 0; writedata = 0; memwrite = 0; ld_we = 0; ld_addr = 0; ld_data = 0;
      out_ready = 0; reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      // Preload during reset
      ld_we = 1;
      ld_addr = 8'd0;  ld_data = 32'h2008_0005; step();
      ld_addr = 8'd1;  ld_data = 32'hAC08_0040; step();
      ld_addr = 8'd2;  ld_data = 32'h0800_0000; step();
      ld_addr = 8'h10; ld_data = 32'h0BAD_0000; step();
      ld_we = 0;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      reset = 1'b0;
      peek(32'h0, 32'h2008_0005, "pre_w0");
      peek(32'h4, 32'hAC08_0040, "pre_w1");
      step();
      peek(32'h8, 32'h0800_0000, "pre_w2");
      peek(IOB, 32'd1, "cycle1");
      step(); step();
      peek(IOB, 32'd3, "cycle3");
      step();

      // CPU RAM write: old value in-cycle, new after the edge
      adr = 32'h40; writedata = 32'h1234_5678; memwrite = 1; #1;
      chk("ram_old", readdata, 32'h0BAD_0000);
      step(); memwrite = 0; #1;
      chk("ram_new", readdata, 32'h1234_5678);
      // Same-word collision: preload wins
      ld_we = 1; ld_addr = 8'h10; ld_data = 32'hAAAA_0000;
      bus_wr(32'h40, 32'h5555_5555);
      ld_we = 0;
      peek(32'h40, 32'hAAAA_0000, "collide");
      step();
      // Different words: both land
      ld_we = 1; ld_addr = 8'h10; ld_data = 32'h1234_5678;
      bus_wr(32'h44, 32'hCAFE_F00D);
      ld_we = 0;
      peek(32'h44, 32'hCAFE_F00D, "both_cpu");
      peek(32'h40, 32'h1234_5678, "both_ld");
      step();

      // Overfill FIFO
      for (int i = 1; i <= 9; i++) bus_wr(IOB + 32'd4, 32'(i));
      peek(IOB + 32'd8, 32'h0000_080A, "status_full");
      peek(IOB + 32'd4, 32'h0, "out_read0");
      out_ready = 1;
      for (int k = 1; k <= 8; k++) begin
         chk("drain", out_data, 32'(k));
         step();
      end
      chk("drained_valid", 32'(out_valid), 32'h0);
      peek(IOB + 32'd8, 32'h0000_0006, "status_empty");
      out_ready = 0;
      bus_wr(IOB + 32'd8, 32'h2);
      peek(IOB + 32'd8, 32'h0000_0004, "ovf_clear");
      step();

      // Push while full with simultaneous pop is dropped
      for (int i = 0; i < 8; i++) bus_wr(IOB + 32'd4, 32'h100 + 32'(i));
      out_ready = 1;
      bus_wr(IOB + 32'd4, 32'h99);
      out_ready = 0;
      peek(IOB + 32'd8, 32'h0000_0702, "full_pushpop");
      chk("full_head", out_data, 32'h101);
      // Push+pop while partly full: count unchanged
      out_ready = 1;
      bus_wr(IOB + 32'd4, 32'hAB);
      peek(IOB + 32'd8, 32'h0000_0702, "pushpop_count");
      for (int i = 0; i < 8; i++) step();
      out_ready = 0;
      bus_wr(IOB + 32'd8, 32'h2);
      step();

      // Bus error path
      bus_wr(32'h402, 32'hFFFF_FFFF);
      chk("err_set", 32'(err_o), 32'h1);
      peek(IOB + 32'd12, 32'h0000_0402, "erraddr");
      peek(32'h0, 32'h2008_0005, "ram_intact");
      step();
      bus_wr(IOB + 32'd8, 32'h1);
      chk("err_clear", 32'(err_o), 32'h0);
      peek(32'h8000_0000, 32'hDEAD_BEEF, "unmapped_rd");
      chk("rd_noerr", 32'(err_o), 32'h0);
      step();

      // Async reset mid-stream
      for (int i = 0; i < 3; i++) bus_wr(IOB + 32'd4, 32'h50 + 32'(i));
      bus_wr(32'h8000_0000, 32'h0);
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      chk("pre_rst_err", 32'(err_o), 32'h1);
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_err", 32'(err_o), 32'h0);
      step(); step();
      reset = 1'b0;
      peek(IOB, 32'h0, "cycle_after_rst");
      peek(32'h40, 32'h1234_5678, "ram_kept");
      step();

      // Counter wrap
      adr = 32'h0;
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1 release dut.cycle_q;
      poke_seq++;
      step();
      peek(IOB, 32'hFFFF_FFFF, "cycle_max");
      step();
      peek(IOB, 32'h0, "cycle_wrap");
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
